// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone initiator: turns a valid/ready command stream into
// pipelined Wishbone cycles with bounded retry, per-attempt timeout and one response per command.
module wb_initiator #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 1024,
    parameter  int MAX_RETRY  = 3,
    localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic [1:0]            rsp_status_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i
);

    localparam int LSB   = $clog2(SEL_WIDTH);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [ADDR_WIDTH-1:0] ADR_MASK =
        ~((ADDR_WIDTH'(1) << LSB) - ADDR_WIDTH'(1));

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_RTY = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_BACKOFF, S_RSP} state_t;

    state_t                state, state_d;
    logic [TMR_W-1:0]      timer, timer_d;
    logic [RTY_W-1:0]      retry_cnt, retry_cnt_d;
    logic                  accept, active, timed_out, retry_ok;
    logic                  cmd_ready_d, rsp_valid_d, cyc_d, stb_d, we_d;
    logic [ADDR_WIDTH-1:0] adr_d;
    logic [SEL_WIDTH-1:0]  sel_d;
    logic [DATA_WIDTH-1:0] wdat_d, rdat_d;
    logic [1:0]            status_d;

    assign accept    = (state == S_IDLE) & cmd_valid_i & cmd_ready_o;
    assign active    = (state == S_REQ) | (state == S_WAIT);
    assign timed_out = (timer == TMR_W'(TIMEOUT));
    assign retry_ok  = (retry_cnt < RTY_W'(MAX_RETRY));

    // every output is a register loaded from its *_d shadow
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            timer        <= '0;
            retry_cnt    <= '0;
            cmd_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_sel_o     <= '0;
            wb_dat_o     <= '0;
        end else begin
            state        <= state_d;
            timer        <= timer_d;
            retry_cnt    <= retry_cnt_d;
            cmd_ready_o  <= cmd_ready_d;
            rsp_valid_o  <= rsp_valid_d;
            rsp_dat_o    <= rdat_d;
            rsp_status_o <= status_d;
            wb_cyc_o     <= cyc_d;
            wb_stb_o     <= stb_d;
            wb_we_o      <= we_d;
            wb_adr_o     <= adr_d;
            wb_sel_o     <= sel_d;
            wb_dat_o     <= wdat_d;
        end
    end

    // termination priority err > rty > ack; a termination beats a coincident timeout
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:    if (accept) state_d = S_REQ;
            S_REQ, S_WAIT: begin
                if (wb_err_i)                    state_d = S_RSP;
                else if (wb_rty_i)               state_d = retry_ok ? S_BACKOFF : S_RSP;
                else if (wb_ack_i || timed_out)  state_d = S_RSP;
                else if (state == S_REQ && !wb_stall_i) state_d = S_WAIT;
            end
            S_BACKOFF: state_d = S_REQ;
            S_RSP:     if (rsp_ready_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        cyc_d       = (state_d == S_REQ) | (state_d == S_WAIT);
        stb_d       = (state_d == S_REQ);
        rsp_valid_d = (state_d == S_RSP);
        we_d        = wb_we_o;
        adr_d       = wb_adr_o;
        sel_d       = wb_sel_o;
        wdat_d      = wb_dat_o;
        rdat_d      = rsp_dat_o;
        status_d    = rsp_status_o;
        timer_d     = timer;
        retry_cnt_d = retry_cnt;
        if (accept) begin
            we_d        = cmd_we_i;
            adr_d       = cmd_adr_i & ADR_MASK;
            sel_d       = cmd_sel_i;
            wdat_d      = cmd_dat_i;
            timer_d     = '0;
            retry_cnt_d = '0;
        end
        if (state == S_BACKOFF) timer_d = '0;
        if (active) begin
            timer_d = timer + 1'b1;
            if (wb_err_i) begin
                status_d = ST_ERR;
                rdat_d   = '0;
            end else if (wb_rty_i) begin
                if (retry_ok) begin
                    retry_cnt_d = retry_cnt + 1'b1;
                end else begin
                    status_d = ST_RTY;
                    rdat_d   = '0;
                end
            end else if (wb_ack_i) begin
                status_d = ST_OK;
                rdat_d   = wb_we_o ? '0 : wb_dat_i;
            end else if (timed_out) begin
                status_d = ST_TMO;
                rdat_d   = '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Scoreboard bench for wb_initiator: a reactive slave task drives bus responses,
// expected responses are queued at command issue and popped on each response handshake.
module tb_wb_initiator;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_RTY = 2'b11;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] dat;
    } exp_t;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_wdat, wb_rdat;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_err, wb_rty, wb_stall;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0, n_errs = 0, n_push = 0, n_rsp = 0;
    int   s_lat, s_stb, s_rise, s_gap, s_att;

    wb_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16), .MAX_RETRY(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
        .wb_adr_o(wb_adr), .wb_sel_o(wb_sel), .wb_dat_o(wb_wdat), .wb_dat_i(wb_rdat),
        .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty), .wb_stall_i(wb_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // response scoreboard: a handshake seen here completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("rsp_status", 64'(rsp_status), 64'(mon_e.status));
                check("rsp_dat", 64'(rsp_dat), 64'(mon_e.dat));
                n_rsp++;
            end
        end
    end

    // call at #1 after an edge; returns at #1 after the accept edge (cycle 1)
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic push,
                         input logic [1:0] es, input logic [31:0] ed);
        int   n = 0;
        exp_t e;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        if (push) begin
            e.status = es;
            e.dat    = ed;
            q.push_back(e);
            n_push++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic respond(input int rty_n, input int fin, input logic [31:0] rdata);
        if (s_att < rty_n) begin
            wb_rty = 1'b1;
        end else begin
            case (fin)
                0: begin wb_ack = 1'b1; wb_rdat = rdata; end
                1: wb_err = 1'b1;
                2: begin wb_ack = 1'b1; wb_err = 1'b1; wb_rdat = rdata; end
                default: ;
            endcase
        end
        s_att++;
    endtask

    // fin: 0 ack, 1 err, 2 ack+err, 3 silent; wait_n = WAIT cycles before answering
    task automatic run_slave(input int stall_n, input int wait_n, input int rty_n,
                             input int fin, input logic [31:0] rdata);
        int stall_left = stall_n;
        int wcnt = 0;
        int k = 1;
        bit prev_stb = 1'b0;
        bit done = 1'b0;
        s_lat = 0; s_stb = 0; s_rise = 0; s_gap = 0; s_att = 0;
        while (!done && k < 60) begin
            {wb_ack, wb_err, wb_rty, wb_stall} = 4'b0;
            wb_rdat = 32'hBAD0_BAD0;
            if (rsp_valid) begin
                s_lat = k;
                done  = 1'b1;
            end else if (wb_stb) begin
                s_stb++;
                if (!prev_stb) s_rise++;
                wcnt = 0;
                if (stall_left > 0) begin
                    wb_stall = 1'b1;
                    stall_left--;
                end else if (wait_n == 0) begin
                    respond(rty_n, fin, rdata);
                end
            end else if (wb_cyc) begin
                if (wcnt == wait_n - 1) respond(rty_n, fin, rdata);
                wcnt++;
            end else begin
                s_gap++;
            end
            prev_stb = wb_stb;
            if (!done) begin
                @(posedge clk); #1;
                k++;
            end
        end
        if (!done) check("rsp_valid_budget", 64'(rsp_valid), 64'd1);
        else       check("cyc_low_in_rsp", 64'(wb_cyc), 64'd0);
    endtask

    initial begin
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b1; wb_rdat = '0; {wb_ack, wb_err, wb_rty, wb_stall} = 4'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_ctl", 64'({cmd_ready, rsp_valid, wb_cyc, wb_stb, wb_we, rsp_status}), 64'd0);
        check("rst_adr", 64'(wb_adr), 64'd0);
        check("rst_wdat", 64'({wb_wdat, wb_sel}), 64'd0);
        check("rst_rdat", 64'(rsp_dat), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 64'(cmd_ready), 64'd1);

        // write, ack in cycle 3
        issue(1'b1, 32'h0000_1006, 32'hDEAD_BEEF, 4'hF, 1'b1, ST_OK, 32'h0);
        check("wr_adr", 64'(wb_adr), 64'h1004);
        check("wr_we", 64'(wb_we), 64'd1);
        check("wr_wdat", 64'(wb_wdat), 64'hDEAD_BEEF);
        check("wr_sel", 64'(wb_sel), 64'hF);
        check("wr_cyc_stb", 64'({wb_cyc, wb_stb}), 64'b11);
        check("wr_busy", 64'(cmd_ready), 64'd0);
        run_slave(0, 2, 0, 0, 32'h0);
        check("wr_lat", 64'(s_lat), 64'd4);
        check("wr_stb_cycles", 64'(s_stb), 64'd1);

        // read with 3 stall cycles, ack on the 4th
        issue(1'b0, 32'h0002_0000, 32'h0, 4'hF, 1'b1, ST_OK, 32'h1234_5678);
        check("rd_adr", 64'(wb_adr), 64'h2_0000);
        check("rd_we", 64'(wb_we), 64'd0);
        run_slave(3, 0, 0, 0, 32'h1234_5678);
        check("stall_lat", 64'(s_lat), 64'd5);
        check("stall_stb_cycles", 64'(s_stb), 64'd4);
        check("stall_stb_rises", 64'(s_rise), 64'd1);

        // err in cycle 2, then ack+err together
        issue(1'b0, 32'h0000_0300, 32'h0, 4'hF, 1'b1, ST_ERR, 32'h0);
        run_slave(0, 1, 0, 1, 32'hCAFE_F00D);
        check("err_lat", 64'(s_lat), 64'd3);
        issue(1'b0, 32'h0000_0304, 32'h0, 4'hF, 1'b1, ST_ERR, 32'h0);
        run_slave(0, 0, 0, 2, 32'hCAFE_F00D);
        check("ackerr_lat", 64'(s_lat), 64'd2);

        // retries exhausted, then ack on third attempt
        issue(1'b0, 32'h0000_0400, 32'h0, 4'hF, 1'b1, ST_RTY, 32'h0);
        run_slave(0, 0, 3, 0, 32'h0);
        check("rty_stb_rises", 64'(s_rise), 64'd3);
        check("rty_cyc_gap", 64'(s_gap), 64'd2);
        check("rty_lat", 64'(s_lat), 64'd6);
        issue(1'b0, 32'h0000_0408, 32'h0, 4'hF, 1'b1, ST_OK, 32'h55AA_1234);
        run_slave(0, 0, 2, 0, 32'h55AA_1234);
        check("rty_ok_stb_rises", 64'(s_rise), 64'd3);
        check("rty_ok_cyc_gap", 64'(s_gap), 64'd2);
        check("rty_ok_lat", 64'(s_lat), 64'd6);

        // silent slave: timeout after TIMEOUT+1 attempt cycles, late ack ignored
        issue(1'b0, 32'h0000_0500, 32'h0, 4'hF, 1'b1, ST_TMO, 32'h0);
        run_slave(0, 0, 0, 3, 32'h0);
        check("tmo_lat", 64'(s_lat), 64'd18);
        check("tmo_stb_cycles", 64'(s_stb), 64'd1);
        @(posedge clk); #1;
        wb_ack = 1'b1; wb_rty = 1'b1; wb_rdat = 32'h7777_7777;
        repeat (2) begin @(posedge clk); #1; end
        {wb_ack, wb_rty} = 2'b0;
        repeat (3) begin
            check("late_ack_no_rsp", 64'(rsp_valid), 64'd0);
            check("late_ack_idle", 64'({cmd_ready, wb_cyc}), 64'b10);
            @(posedge clk); #1;
        end

        // response back-pressure for 5 cycles
        rsp_ready = 1'b0;
        issue(1'b0, 32'h0000_0600, 32'h0, 4'hF, 1'b1, ST_OK, 32'hA5A5_0001);
        run_slave(0, 0, 0, 0, 32'hA5A5_0001);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_dat", 64'(rsp_dat), 64'hA5A5_0001);
            check("hold_status", 64'(rsp_status), 64'(ST_OK));
            check("hold_not_ready", 64'(cmd_ready), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release", 64'(rsp_valid), 64'd0);

        // asynchronous reset while in WAIT; command is discarded
        issue(1'b0, 32'h0000_0A08, 32'h1111_2222, 4'h3, 1'b0, ST_OK, 32'h0);
        @(posedge clk); #1;
        check("pre_rst_wait", 64'({wb_cyc, wb_stb}), 64'b10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", 64'({cmd_ready, rsp_valid, wb_cyc, wb_stb, wb_we, rsp_status}), 64'd0);
        check("mid_rst_adr", 64'(wb_adr), 64'd0);
        check("mid_rst_wdat", 64'({wb_wdat, wb_sel}), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst2", 64'({cmd_ready, wb_cyc}), 64'b10);

        // recovery transaction after reset
        issue(1'b1, 32'h0000_0044, 32'h0BAD_CAFE, 4'hC, 1'b1, ST_OK, 32'h0);
        run_slave(0, 0, 0, 0, 32'h0);
        check("post_rst_lat", 64'(s_lat), 64'd2);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 64'(q.size()), 64'd0);
        check("rsp_count", 64'(n_rsp), 64'(n_push));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
